// File: rtl/dp_iso_pkg.sv
// Shared constants and types for the DisplayPort iso lane path.
// K-codes, scrambler polynomial/seed, scrambler state, output bundle.
package dp_iso_pkg;

  localparam logic [7:0]  K_BS          = 8'hBC;
  localparam logic [7:0]  K_SR          = 8'h1C;
  localparam logic [15:0] SCR_POLY_MASK = 16'h0039;
  localparam logic [15:0] SCR_SEED      = 16'hFFFF;

  typedef enum logic {
    BYPASS,
    SCRAMBLE
  } scr_state_e;

  typedef struct packed {
    logic [7:0] sym;
    logic       flag;
    logic       sr;
  } scr_out_t;

endpackage

// File: rtl/lane_scrambler_if.sv
// Lane symbol bundle between iso stage, scrambler and 8b/10b encoder.
// master: drives iso_* and scr_bypass; slave: drives scr_* outputs.
interface lane_scrambler_if;

  logic [7:0] iso_symbols;
  logic       iso_control_sym_flag;
  logic       scr_bypass;
  logic [7:0] scr_symbols;
  logic       scr_control_sym_flag;
  logic       scr_sr_inserted;

  modport master (
    output iso_symbols,
    output iso_control_sym_flag,
    output scr_bypass,
    input  scr_symbols,
    input  scr_control_sym_flag,
    input  scr_sr_inserted
  );

  modport slave (
    input  iso_symbols,
    input  iso_control_sym_flag,
    input  scr_bypass,
    output scr_symbols,
    output scr_control_sym_flag,
    output scr_sr_inserted
  );

endinterface

// File: rtl/lane_scrambler_lfsr16.sv
// 16-bit Galois LFSR, 8 steps per symbol, key bit k from s[15].
// Ports: clk, rst_n, load (seed), adv (8 steps) -> state, keystream.
module scr_lfsr16
  import dp_iso_pkg::*;
#(
  parameter logic [15:0] SEED = SCR_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        adv,
  output logic [15:0] state,
  output logic [7:0]  keystream
);

  logic [15:0] w_next;

  always_comb begin
    logic [15:0] s;
    s         = state;
    keystream = '0;
    for (int k = 0; k < 8; k++) begin
      keystream[k] = s[15];
      s = {s[14:0], 1'b0} ^
          (s[15] ? SCR_POLY_MASK : 16'h0000);
    end
    w_next = s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (adv) begin
      state <= w_next;
    end
  end

endmodule

// File: rtl/lane_scrambler.sv
// Per-lane DP scrambler: BS->SR every BS_PERIOD, data XOR keystream.
// Ports: clk, rst_n, lane (slave: iso_* in, scr_bypass in, scr_* out).
module lane_scrambler
  import dp_iso_pkg::*;
#(
  parameter int          BS_PERIOD = 512,
  parameter logic [15:0] LFSR_SEED = SCR_SEED
) (
  input  logic            clk,
  input  logic            rst_n,
  lane_scrambler_if.slave lane
);

  localparam int CW =
    (BS_PERIOD > 1) ? $clog2(BS_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(BS_PERIOD - 1);

  scr_state_e    r_state;
  logic [CW-1:0] r_bs_cnt;
  scr_out_t      r_out;

  logic [CW-1:0] w_cnt_cur;
  logic          w_byp;
  logic          w_is_bs;
  logic          w_is_sr;
  logic          w_wrap;
  logic          w_pass_k;
  logic          w_data;
  logic          w_load;
  logic          w_adv;
  logic [15:0]   w_lfsr;
  logic [7:0]    w_key;
  scr_out_t      w_nxt;

  assign w_byp   = lane.scr_bypass;
  assign w_is_bs = lane.iso_control_sym_flag &
                   (lane.iso_symbols == K_BS);
  assign w_is_sr = lane.iso_control_sym_flag &
                   (lane.iso_symbols == K_SR);

  // A period only runs while in SCRAMBLE.
  assign w_cnt_cur =
    (r_state == SCRAMBLE) ? r_bs_cnt : '0;

  assign w_wrap   = ~w_byp & w_is_bs &
                    (w_cnt_cur == LAST);
  assign w_pass_k = ~w_byp & ~w_wrap &
                    lane.iso_control_sym_flag;
  assign w_data   = ~w_byp &
                    ~lane.iso_control_sym_flag;

  // Upstream SR re-seeds just like an inserted one.
  assign w_load = w_byp | w_wrap |
                  (~w_byp & w_is_sr);
  assign w_adv  = ~w_byp;

  scr_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_load),
    .adv       (w_adv),
    .state     (w_lfsr),
    .keystream (w_key)
  );

  always_comb begin
    w_nxt.sym  = lane.iso_symbols;
    w_nxt.flag = lane.iso_control_sym_flag;
    w_nxt.sr   = 1'b0;
    unique case (1'b1)
      w_byp: ;
      w_wrap: begin
        w_nxt.sym  = K_SR;
        w_nxt.flag = 1'b1;
        w_nxt.sr   = 1'b1;
      end
      w_pass_k: ;
      w_data: begin
        w_nxt.sym = lane.iso_symbols ^ w_key;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= BYPASS;
      r_bs_cnt <= '0;
      r_out    <= '0;
    end else begin
      r_out   <= w_nxt;
      r_state <= w_byp ? BYPASS : SCRAMBLE;
      if (w_byp || w_wrap) begin
        r_bs_cnt <= '0;
      end else if (w_is_bs) begin
        r_bs_cnt <= w_cnt_cur + 1'b1;
      end else begin
        r_bs_cnt <= w_cnt_cur;
      end
    end
  end

  assign lane.scr_symbols          = r_out.sym;
  assign lane.scr_control_sym_flag = r_out.flag;
  assign lane.scr_sr_inserted      = r_out.sr;

endmodule

// File: tb/tb_lane_scrambler.sv
// Scoreboard bench for lane_scrambler against a behavioural model.
// Random lane traffic, SR wrap, upstream SR, async reset, bypass.
module tb_lane_scrambler;

  typedef struct packed {
    logic [7:0] sym;
    logic       flag;
    logic       sr;
  } exp_t;

  logic clk;
  logic rst_n;

  lane_scrambler_if lane();

  lane_scrambler u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .lane  (lane)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_sr_exp = 0;
  int n_sr_seen = 0;
  bit in_reset = 1'b1;

  exp_t q_pend[$];
  exp_t q_cmp[$];

  logic [15:0] m_lfsr = 16'hFFFF;
  int          m_bs = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  function automatic logic [7:0] next_key();
    logic [7:0] k;
    k = 8'h00;
    for (int i = 0; i < 8; i++) begin
      k[i] = m_lfsr[15];
      if (m_lfsr[15])
        m_lfsr = (m_lfsr << 1) ^ 16'h0039;
      else
        m_lfsr = m_lfsr << 1;
    end
    return k;
  endfunction

  task automatic model(input logic [7:0] s,
                       input logic f,
                       input logic b,
                       output exp_t e);
    e = '{sym: s, flag: f, sr: 1'b0};
    if (b) begin
      m_lfsr = 16'hFFFF;
      m_bs   = 0;
    end else if (f && s == 8'hBC) begin
      m_bs++;
      if (m_bs == 512) begin
        e = '{sym: 8'h1C, flag: 1'b1, sr: 1'b1};
        m_bs = 0;
        m_lfsr = 16'hFFFF;
        n_sr_exp++;
      end else begin
        void'(next_key());
      end
    end else if (f && s == 8'h1C) begin
      m_lfsr = 16'hFFFF;
    end else if (f) begin
      void'(next_key());
    end else begin
      e.sym = s ^ next_key();
    end
  endtask

  task automatic send(input logic [7:0] s,
                      input logic f,
                      input logic b);
    exp_t e;
    @(posedge clk);
    #1;
    lane.iso_symbols          = s;
    lane.iso_control_sym_flag = f;
    lane.scr_bypass           = b;
    model(s, f, b, e);
    q_pend.push_back(e);
  endtask

  task automatic send_rand(input logic b);
    int r;
    logic [7:0] kc [4];
    kc[0] = 8'h7C; kc[1] = 8'hFC;
    kc[2] = 8'h5C; kc[3] = 8'h3C;
    r = $urandom_range(0, 99);
    if (r < 45)
      send(8'hBC, 1'b1, b);
    else if (r < 50)
      send(kc[$urandom_range(0, 3)], 1'b1, b);
    else
      send(8'($urandom), 1'b0, b);
  endtask

  task automatic send_bs(input int n);
    int got;
    got = 0;
    while (got < n) begin
      if ($urandom_range(0, 1) == 0) begin
        send(8'hBC, 1'b1, 1'b0);
        got++;
      end else begin
        send(8'($urandom), 1'b0, 1'b0);
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst_n && !in_reset)
      while (q_pend.size() > 0)
        q_cmp.push_back(q_pend.pop_front());
  end

  always @(negedge clk) begin
    exp_t e;
    if (!in_reset) begin
      if (lane.scr_sr_inserted) n_sr_seen++;
      if (q_cmp.size() > 0) begin
        e = q_cmp.pop_front();
        chk("scoreboard sym/flag/sr",
            {22'd0, lane.scr_symbols,
             lane.scr_control_sym_flag,
             lane.scr_sr_inserted},
            {22'd0, e});
      end
    end
  end

  task automatic do_reset_mid();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    in_reset = 1'b1;
    #1;
    chk("async rst sym", {24'd0, lane.scr_symbols}, 0);
    chk("async rst flag",
        {31'd0, lane.scr_control_sym_flag}, 0);
    chk("async rst sr", {31'd0, lane.scr_sr_inserted}, 0);
    foreach (q_pend[i]) if (q_pend[i].sr) n_sr_exp--;
    foreach (q_cmp[i]) if (q_cmp[i].sr) n_sr_exp--;
    q_pend.delete();
    q_cmp.delete();
    lane.scr_bypass = 1'b1;
    m_lfsr = 16'hFFFF;
    m_bs = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    in_reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    lane.iso_symbols = 8'h00;
    lane.iso_control_sym_flag = 1'b0;
    lane.scr_bypass = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset sym", {24'd0, lane.scr_symbols}, 0);
    chk("reset flag",
        {31'd0, lane.scr_control_sym_flag}, 0);
    chk("reset sr", {31'd0, lane.scr_sr_inserted}, 0);
    chk("reset lfsr", {16'd0, u_dut.u_lfsr.state},
        32'hFFFF);
    rst_n = 1'b1;
    in_reset = 1'b0;

    send(8'h00, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    chk("lfsr after 1st", {16'd0, u_dut.u_lfsr.state},
        32'hE817);
    chk("out 1st", {24'd0, lane.scr_symbols}, 32'hFF);
    send(8'h00, 1'b0, 1'b0);
    chk("lfsr after 2nd", {16'd0, u_dut.u_lfsr.state},
        32'h0328);
    chk("out 2nd", {24'd0, lane.scr_symbols}, 32'h17);
    for (int i = 0; i < 20; i++) send_rand(1'b0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0)
        send(8'hA5, 1'b0, 1'b1);
      else
        send(8'hBC, 1'b1, 1'b1);
    end
    send(8'hBC, 1'b1, 1'b1);
    send(8'h00, 1'b0, 1'b1);
    chk("bypass bs_cnt", {23'd0, u_dut.r_bs_cnt}, 0);

    send_bs(1100);
    for (int i = 0; i < 30; i++) send_rand(1'b0);

    send(8'h1C, 1'b1, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) send_rand(1'b0);

    send_bs(300);
    do_reset_mid();
    send(8'h00, 1'b0, 1'b0);
    send_bs(600);

    while (m_bs != 511) send_rand(1'b0);
    send(8'hBC, 1'b1, 1'b1);
    send(8'h00, 1'b0, 1'b0);
    send_bs(600);
    for (int i = 0; i < 200; i++) send_rand(1'b0);

    repeat (4) @(posedge clk);
    #2;
    chk("queues drained",
        q_pend.size() + q_cmp.size(), 0);
    chk("sr pulse count", n_sr_seen, n_sr_exp);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lane_scrambler.md
# lane_scrambler

Per-lane DisplayPort scrambler and SR inserter directly downstream of the isochronous transport output. It takes one lane's 8-bit symbol and control flag each link-symbol clock. It replaces every 512th BS control symbol with SR, and XORs data symbols with a 16-bit LFSR keystream that re-seeds on every SR. Four instances sit between the isochronous lanes and the 8b/10b encoders.

## Interface
Parameters:
- BS_PERIOD, 512: number of BS symbols per SR. The BS that completes each period is replaced by SR.
- LFSR_SEED, 16'hFFFF: LFSR value loaded on reset, on SR and during bypass.

Ports:
- clk  in  1  link symbol clock (ls_clk domain). One symbol per cycle.
- rst_n  in  1  asynchronous, active-low reset.
- iso_symbols  in  8  lane symbol from the isochronous stage.
- iso_control_sym_flag  in  1  1 = iso_symbols is a K-code.
- scr_bypass  in  1  1 = pass symbols through unmodified. Used for link training patterns.
- scr_symbols  out  8  scrambled or replaced symbol, registered.
- scr_control_sym_flag  out  1  registered copy of the control flag.
- scr_sr_inserted  out  1  one-cycle pulse aligned with an SR on scr_symbols.

## Operation
- Constants: BS = 8'hBC (K28.5), SR = 8'h1C (K28.0). Polynomial x^16+x^5+x^4+x^3+1, Galois mask 16'h0039.
- LFSR step, applied once per bit k = 0..7, with data bit k sent LSB first:
  - key_k = s[15].
  - s = {s[14:0],1'b0} ^ (s[15] ? 16'h0039 : 16'h0000).
- bs_cnt, width $clog2(BS_PERIOD), counts BS symbols. It increments only on input symbols where iso_control_sym_flag = 1 and iso_symbols = BS.
- Per input symbol, when scr_bypass = 0:
  - BS with bs_cnt = BS_PERIOD-1:
    - output SR with flag 1; pulse scr_sr_inserted.
    - bs_cnt wraps to 0; LFSR loads LFSR_SEED.
  - Any other symbol with flag 1, including BS: output unchanged. LFSR advances 8 steps.
  - Flag 0: output iso_symbols XOR key[7:0], where key bit k = key_k. LFSR advances 8 steps.
  - An upstream SR (flag 1, value 8'h1C) is passed through and re-seeds the LFSR. It does not count as BS and does not pulse scr_sr_inserted.
- When scr_bypass = 1:
  - symbol and flag are registered unchanged.
  - LFSR is held at LFSR_SEED, bs_cnt is held at 0, no SR is inserted.
- Deasserting scr_bypass starts a fresh period. The first data symbol is XORed with the seed keystream (0xFF).
- State machine, two states:
  - BYPASS: entered on reset and whenever scr_bypass = 1.
  - SCRAMBLE: entered on the cycle after scr_bypass = 0 is sampled.
  - The state only gates bs_cnt and LFSR updates. Symbol routing is decided from the current-cycle scr_bypass.

## Timing
- Latency is exactly 1 clk from input to output for every symbol, with no bubbles or backpressure.
- Reset values: scr_symbols = 8'h00, scr_control_sym_flag = 0, scr_sr_inserted = 0, LFSR = LFSR_SEED, bs_cnt = 0, state = BYPASS.
- Reset asserted mid-stream clears all state immediately. After release, counting and the keystream restart from the seed.
- The LFSR update and the output XOR use the LFSR value present at the start of the cycle, so a re-seed affects the next symbol.
- scr_bypass toggling in the same cycle as the replacement BS: bypass wins. The BS passes unchanged, no pulse, bs_cnt cleared.
- Wrap-around: BS number 512, 1024, … (counting from 1 after reset or after leaving bypass) becomes SR. Spacing in symbols is irrelevant; only BS occurrences count.

## Structure
- Shared package dp_iso_pkg holds:
  - K_BS = 8'hBC, K_SR = 8'h1C.
  - SCR_POLY_MASK = 16'h0039, SCR_SEED = 16'hFFFF.
  - State enum scr_state_e {BYPASS, SCRAMBLE}.
- One sub-module, scr_lfsr16:
  - inputs: clk, rst_n, load, adv.
  - outputs: 16-bit state and 8-bit keystream, computed by unrolling 8 Galois steps.
- lane_scrambler holds the BS counter, control decode and output registers.

## Test plan
- Reset, bypass = 0, data 0x00 streamed (flag 0) -> outputs 0xFF, then 0x17 after 1 clk latency. Internal LFSR 16'hE817, then 16'h0328.
- Bypass = 1 with 0xA5 data and BS symbols -> identical symbols and flags out, never an SR, bs_cnt stays 0.
- 511 BS (flag 1) interleaved with data, then a 512th BS -> 512th output is 8'h1C with flag 1 and scr_sr_inserted = 1. The next 0x00 data symbol outputs 0xFF. The 1024th BS again becomes SR.
- Upstream SR (8'h1C, flag 1) injected mid-line -> passed through, no pulse, the following 0x00 data outputs 0xFF, bs_cnt unchanged.
- rst_n pulsed low asynchronously mid-line after 300 BS -> outputs 0 immediately. After release, the 512th BS counted from release is replaced and the first data 0x00 outputs 0xFF.
- scr_bypass raised on the same cycle as the 512th BS -> BS 0xBC passes, no pulse. After bypass drops, 512 further BS are needed before the next SR.
